// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg
// Purpose: shared types and constants for the UART control slice.
//   arb_state_t - states of the transmitter arbiter FSM
//   UART_BYTE_W - width of one transmitted byte
package uart_ctrl_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Purpose: combinational round-robin winner selection.
// Ports:
//   req        - in,  N_REQ : pending requests
//   last_owner - in,  IDX_W : index of the most recently served requester
//   win_onehot - out, N_REQ : one-hot winner (all zero when nothing is pending)
//   win_idx    - out, IDX_W : binary index of the winner
//   any        - out, 1     : at least one request is pending
module rr_pick #(
  parameter int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_owner,
  output logic [N_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  int               cand;
  logic [IDX_W-1:0] candIdx;

  // Walk the requesters starting just after the last owner and wrapping
  // around; the last owner itself is visited last, so it only wins again
  // when nobody else is asking.
  always_comb begin
    win_onehot = '0;
    win_idx    = last_owner;
    any        = 1'b0;
    cand       = 0;
    candIdx    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(last_owner) + k;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      candIdx = IDX_W'(cand);
      if (!any && req[candIdx]) begin
        any        = 1'b1;
        win_idx    = candIdx;
        win_onehot = N_REQ'(1) << candIdx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Purpose: shares one uart_tx among N_REQ byte producers. Grants one
// requester per byte in round-robin order, drives the send/busy handshake
// and reports a transmitter that never raises busy.
// Ports:
//   clk, rst_n   - clock and synchronous active-low reset
//   req          - in,  N_REQ   : per-requester request, held until gnt
//   req_data     - in,  N_REQ*8 : byte i on bits [8i+7:8i]
//   gnt          - out, N_REQ   : one-cycle one-hot grant
//   owner        - out, IDX_W   : index of the last granted requester
//   active       - out, 1       : transfer in progress
//   timeout_err  - out, 1       : one-cycle pulse, busy never rose
//   tx_data      - out, 8       : byte presented to uart_tx
//   tx_send      - out, 1       : one-cycle start pulse to uart_tx
//   tx_busy      - in,  1       : busy flag from uart_tx
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ*UART_BYTE_W-1:0] req_data,
  output logic [N_REQ-1:0]             gnt,
  output logic [$clog2(N_REQ)-1:0]     owner,
  output logic                         active,
  output logic                         timeout_err,
  output logic [UART_BYTE_W-1:0]       tx_data,
  output logic                         tx_send,
  input  logic                         tx_busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  arb_state_t             state_q, state_d;
  logic [N_REQ-1:0]       gnt_q, gnt_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic                   active_q, active_d;
  logic                   timeoutErr_q, timeoutErr_d;
  logic [UART_BYTE_W-1:0] txData_q, txData_d;
  logic                   txSend_q, txSend_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [N_REQ-1:0]       pickOnehot;
  logic [IDX_W-1:0]       pickIdx;
  logic                   pickAny;
  logic [UART_BYTE_W-1:0] pickData;

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req       (req),
    .last_owner(owner_q),
    .win_onehot(pickOnehot),
    .win_idx   (pickIdx),
    .any       (pickAny)
  );

  // One-hot mux of the winner's byte; avoids a variable-width part select.
  always_comb begin
    pickData = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pickOnehot[i]) begin
        pickData = req_data[i*UART_BYTE_W +: UART_BYTE_W];
      end
    end
  end

  // State and output registers. Owner resets to the top index so that
  // requester 0 is searched first after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      owner_q      <= IDX_W'(N_REQ - 1);
      active_q     <= 1'b0;
      timeoutErr_q <= 1'b0;
      txData_q     <= '0;
      txSend_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      owner_q      <= owner_d;
      active_q     <= active_d;
      timeoutErr_q <= timeoutErr_d;
      txData_q     <= txData_d;
      txSend_q     <= txSend_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state logic. A busy flag already high on entry to WAIT_BUSY moves
  // straight on to WAIT_DONE, which then waits for it to fall.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pickAny) begin
          state_d = SEND;
        end
      end
      SEND: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered-output next values. gnt/tx_send/timeout_err default low so
  // each is a single-cycle pulse; tx_data holds between transfers. The
  // counter stops at all-ones instead of wrapping.
  always_comb begin
    gnt_d        = '0;
    txSend_d     = 1'b0;
    timeoutErr_d = 1'b0;
    owner_d      = owner_q;
    txData_d     = txData_q;
    active_d     = active_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pickAny) begin
          gnt_d    = pickOnehot;
          owner_d  = pickIdx;
          txData_d = pickData;
          txSend_d = 1'b1;
          active_d = 1'b1;
        end
      end
      SEND: begin
        cnt_d = '0;
      end
      WAIT_BUSY: begin
        if (!tx_busy) begin
          if (cnt_q == CNT_LAST) begin
            timeoutErr_d = 1'b1;
            active_d     = 1'b0;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          active_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign gnt         = gnt_q;
  assign owner       = owner_q;
  assign active      = active_q;
  assign timeout_err = timeoutErr_q;
  assign tx_data     = txData_q;
  assign tx_send     = txSend_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares the single `uart_tx` transmitter among `N_REQ` byte producers, such as the RX decode path, status reporters and debug taps. It sits between the requesters and `uart_tx` in `fpga_top`. It grants one requester per byte, sequences the transmitter's `send`/`busy` handshake, and flags a transmitter that never starts.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2–8.
- `BUSY_TIMEOUT`, default 16: maximum number of cycles after `tx_send` before `tx_busy` must rise.
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, synchronous, active-low. One clock; all state updates on the rising edge of `clk`.
- `req`, in, `N_REQ`: per-requester request. The requester holds it until it receives `gnt`.
- `req_data`, in, `N_REQ*8`: byte of requester i on bits `[8i+7:8i]`. Must be stable while `req[i]` is high.
- `gnt`, out, `N_REQ`: one-hot, single-cycle pulse. The byte of that requester has been accepted.
- `owner`, out, `$clog2(N_REQ)`: index of the last granted requester.
- `active`, out, 1: high from the grant until the transfer completes or times out.
- `timeout_err`, out, 1: single-cycle pulse when `tx_busy` fails to rise within `BUSY_TIMEOUT` cycles.
- `tx_data`, out, 8: byte to `uart_tx.data_in`; held constant for the whole transfer.
- `tx_send`, out, 1: single-cycle start pulse to `uart_tx.send`.
- `tx_busy`, in, 1: from `uart_tx.busy`.

## Operation
- States:
  - IDLE: waiting for a request.
  - SEND: start pulse issued.
  - WAIT_BUSY: waiting for `tx_busy` to rise.
  - WAIT_DONE: waiting for `tx_busy` to fall.
- IDLE with `req != 0`:
  - Select the winner by round-robin, searching from `(owner+1) mod N_REQ` upward with wrap.
  - Register `gnt <= onehot(winner)`, `owner <= winner`, `tx_data <= req_data[winner]`, `tx_send <= 1`, `active <= 1`, then go to SEND.
- IDLE with `req == 0`: remain in IDLE; `tx_data` keeps its last value.
- SEND: `gnt` and `tx_send` clear on the next edge. Clear the timeout counter and go to WAIT_BUSY.
- WAIT_BUSY:
  - If `tx_busy` = 1, go to WAIT_DONE.
  - Otherwise increment the counter.
  - When the counter reaches `BUSY_TIMEOUT-1` and `tx_busy` is still 0: pulse `timeout_err`, clear `active`, go to IDLE. The byte is dropped, with no retry.
- WAIT_DONE: when `tx_busy` = 0, clear `active` and go to IDLE.
- Requests arriving outside IDLE are ignored until the next IDLE cycle; the request must still be held then.
- A `req[i]` withdrawn before its grant is legal and is simply not served.
- `tx_busy` already high while in IDLE: the arbiter still grants. The SEND → WAIT_BUSY path then sees busy immediately, and completion waits for `tx_busy` to fall.
- Counter width: `$clog2(BUSY_TIMEOUT+1)`. It saturates and never wraps.

## Timing
- Reset values:
  - State IDLE.
  - `gnt`=0, `tx_send`=0, `active`=0, `timeout_err`=0, `tx_data`=8'h00.
  - `owner`=`N_REQ-1`, so requester 0 has first priority after reset.
- Grant latency: `req` sampled high in IDLE at edge k. `gnt`, `tx_send` and `active` are high in the cycle after edge k.
- `gnt` and `tx_send` are coincident, each exactly one cycle wide.
- Back-to-back: `tx_busy` sampled low in WAIT_DONE at edge e → IDLE. The next grant is registered at edge e+1, giving a minimum 2-cycle gap between the fall of `busy` and the next `tx_send`.
- Timeout: `timeout_err` is high in the cycle exactly `BUSY_TIMEOUT+1` edges after the edge that set `tx_send`.
- Reset mid-operation: reset wins at the next edge regardless of state or `tx_busy`. All outputs take their reset values, and the in-flight grant is forgotten. `uart_tx` shares `rst_n`.

## Structure
- Shared package `uart_ctrl_pkg`:
  - `arb_state_t` enum (IDLE, SEND, WAIT_BUSY, WAIT_DONE).
  - `UART_BYTE_W` = 8.
- Sub-module `rr_pick`: purely combinational, parameterised on `N_REQ`.
  - Inputs: `req` and the last owner.
  - Outputs: one-hot winner, winner index, `any`.
- The arbiter top holds the FSM, registers and counter. It is instantiated in `fpga_top` ahead of `uart_tx`.

## Test plan
- Single request: after reset, `req`=4'b0100 with data 8'hA5 → `gnt`=4'b0100 and `tx_send` one cycle later, `tx_data`=8'hA5. Model `busy` high for 10 cycles → `active` falls the cycle after `busy` falls.
- Fairness: `req`=4'b1111 held, distinct bytes → grant order 0,1,2,3,0; each `tx_send` is at least 2 cycles after the previous `busy` fall.
- Wrap: `owner`=3 with `req`=4'b1001 → requester 0 granted; next grant goes to 3.
- Timeout: `tx_busy` stuck 0, `BUSY_TIMEOUT`=16 → `timeout_err` pulses 17 edges after `tx_send`, the FSM returns to IDLE, and the next request is served normally.
- Reset mid-transfer: `rst_n` low during WAIT_DONE → next cycle all outputs take reset values and `owner`=3. A pending `req`=4'b0010 is granted 1 cycle after reset releases.
- Withdrawal: `req[1]` pulsed for 1 cycle while in WAIT_DONE → never granted, and `gnt` stays 0.
